// File: rtl/ring_pkg.sv
// Shared constants, state encoding and fault codes for ring counter consumers.
package ring_pkg;

    localparam int N  = 16;
    localparam int CW = 4;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_ONEHOT = 2'b01,
        ERR_ENC    = 2'b10,
        ERR_SKIP   = 2'b11
    } err_t;

endpackage

// File: rtl/ring_monitor_if.sv
// Bundle of sampled ring inputs and monitor status outputs.
interface ring_monitor_if #(
    parameter int N     = 16,
    parameter int CW    = 4,
    parameter int LAP_W = 8
);
    logic             CLR;
    logic [0:N-1]     Q;
    logic [CW-1:0]    C;
    logic [CW-1:0]    POS;
    logic             TRACKING;
    logic             WRAP;
    logic [LAP_W-1:0] LAP_CNT;
    logic             FAULT;
    logic [1:0]       ERR_CODE;

    modport master (
        output CLR, Q, C,
        input  POS, TRACKING, WRAP, LAP_CNT, FAULT, ERR_CODE
    );

    modport slave (
        input  CLR, Q, C,
        output POS, TRACKING, WRAP, LAP_CNT, FAULT, ERR_CODE
    );
endinterface

// File: rtl/ring_monitor_onehot_decode.sv
// Combinational one-hot decoder: index of the set bit plus a one-hot flag.
module onehot_decode #(
    parameter int N  = 16,
    parameter int CW = 4
) (
    input  logic [0:N-1]  q,
    output logic [CW-1:0] idx,
    output logic          onehot
);
    localparam int PW = $clog2(N + 1);

    logic [PW-1:0] cnt;

    // OR-ing indices is exact whenever exactly one bit is set
    always_comb begin
        idx = '0;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            if (q[i]) begin
                idx = idx | CW'(i);
                cnt = cnt + 1'b1;
            end
        end
        onehot = (cnt == PW'(1));
    end
endmodule

// File: rtl/ring_monitor.sv
// Checks a one-hot ring and its encoder each cycle, tracks position and laps,
// and latches the first fault cause until cleared.
module ring_monitor
    import ring_pkg::*;
#(
    parameter int N     = ring_pkg::N,
    parameter int CW    = ring_pkg::CW,
    parameter int LAP_W = 8
) (
    input  logic           CLK,
    input  logic           RST,
    ring_monitor_if.slave  bus
);
    state_t           state_q, state_d;
    err_t             err_q, err_d;
    logic [CW-1:0]    pos_q, pos_d;
    logic [LAP_W-1:0] lap_q, lap_d;
    logic             wrap_q, wrap_d;

    logic [CW-1:0] idx;
    logic          onehot;
    logic          enc_ok;
    logic          step_ok;

    onehot_decode #(.N(N), .CW(CW)) u_decode (
        .q      (bus.Q),
        .idx    (idx),
        .onehot (onehot)
    );

    assign enc_ok  = (bus.C == idx);
    assign step_ok = (idx == CW'(pos_q + 1'b1));

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        pos_d   = pos_q;
        lap_d   = lap_q;
        wrap_d  = 1'b0;
        if (bus.CLR) begin
            state_d = SYNC;
            err_d   = ERR_NONE;
            lap_d   = '0;
        end else begin
            case (state_q)
                SYNC: begin
                    if (onehot && enc_ok) begin
                        pos_d   = idx;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (onehot && enc_ok && step_ok) begin
                        pos_d = idx;
                        if (pos_q == CW'(N - 1) && idx == '0) begin
                            wrap_d = 1'b1;
                            if (lap_q != {LAP_W{1'b1}})
                                lap_d = lap_q + 1'b1;
                        end
                    end else begin
                        state_d = FAULT;
                        if (!onehot)
                            err_d = ERR_ONEHOT;
                        else if (!enc_ok)
                            err_d = ERR_ENC;
                        else
                            err_d = ERR_SKIP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= SYNC;
            err_q   <= ERR_NONE;
            pos_q   <= '0;
            lap_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            pos_q   <= pos_d;
            lap_q   <= lap_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.POS      = pos_q;
    assign bus.TRACKING = (state_q == TRACK);
    assign bus.FAULT    = (state_q == FAULT);
    assign bus.WRAP     = wrap_q;
    assign bus.LAP_CNT  = lap_q;
    assign bus.ERR_CODE = err_q;
endmodule
